// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default configuration for the memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic {
        StIdle = 1'b0,
        StBusy = 1'b1
    } arb_state_e;

    localparam int unsigned DefNumReq        = 4;
    localparam int unsigned DefAddrWidth     = 20;
    localparam int unsigned DefSelBits       = 4;
    localparam int unsigned DefTimeoutCycles = 16;

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester at or after (last + 1), with wrap.
module mem_port_arbiter_rr_pick #(
    parameter  int unsigned NumReq = 4,
    localparam int unsigned IdxW   = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic [NumReq-1:0] onehot_o,
    output logic [IdxW-1:0]   idx_o,
    output logic              any_o
);

    logic            found;
    logic [IdxW-1:0] cand;

    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand = IdxW'((32'(last_i) + k) % NumReq);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                idx_o          = cand;
                onehot_o[cand] = 1'b1;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin owner of a shared memory port with registered address and chip-select decode.
// Optional bus timeout abort is enabled by defining ARB_TIMEOUT_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ        = DefNumReq,
    parameter int unsigned ADDR_WIDTH     = DefAddrWidth,
    parameter int unsigned SEL_BITS       = DefSelBits,
    parameter int unsigned TIMEOUT_CYCLES = DefTimeoutCycles
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          req_err,
    output logic [NUM_REQ-1:0]            grant,
    output logic                          bus_valid,
    output logic [ADDR_WIDTH-1:0]         bus_addr,
    output logic [(1<<SEL_BITS)-1:0]      bus_cs,
    input  logic                          bus_ack
);

    localparam int unsigned IdxW  = $clog2(NUM_REQ);
    localparam int unsigned NumCs = 1 << SEL_BITS;

    arb_state_e              state_q, state_d;
    logic [NUM_REQ-1:0]      grant_q, grant_d;
    logic                    bus_valid_q, bus_valid_d;
    logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
    logic [NumCs-1:0]        bus_cs_q, bus_cs_d;
    logic [NUM_REQ-1:0]      req_done_q, req_done_d;
    logic                    req_err_q, req_err_d;
    logic [IdxW-1:0]         last_q, last_d;
    logic [IdxW-1:0]         owner_q, owner_d;

    logic [NUM_REQ-1:0]      win_onehot;
    logic [IdxW-1:0]         win_idx;
    logic                    win_any;
    logic [ADDR_WIDTH-1:0]   win_addr;
    logic [SEL_BITS-1:0]     win_sel;
    logic [NumCs-1:0]        win_cs;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYCLES;
`endif

    mem_port_arbiter_rr_pick #(
        .NumReq (NUM_REQ)
    ) u_rr_pick (
        .req_i    (req_valid),
        .last_i   (last_q),
        .onehot_o (win_onehot),
        .idx_o    (win_idx),
        .any_o    (win_any)
    );

    always_comb begin
        win_addr         = req_addr[32'(win_idx) * ADDR_WIDTH +: ADDR_WIDTH];
        win_sel          = win_addr[ADDR_WIDTH-1 -: SEL_BITS];
        win_cs           = '0;
        win_cs[win_sel]  = 1'b1;
    end

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        bus_valid_d = bus_valid_q;
        bus_addr_d  = bus_addr_q;
        bus_cs_d    = bus_cs_q;
        last_d      = last_q;
        owner_d     = owner_q;
        // Completion flags are single-cycle pulses.
        req_done_d  = '0;
        req_err_d   = 1'b0;
`ifdef ARB_TIMEOUT_EN
        cnt_d       = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (win_any) begin
                    state_d     = StBusy;
                    grant_d     = win_onehot;
                    bus_valid_d = 1'b1;
                    bus_addr_d  = win_addr;
                    bus_cs_d    = win_cs;
                    owner_d     = win_idx;
`ifdef ARB_TIMEOUT_EN
                    cnt_d       = '0;
`endif
                end
            end
            StBusy: begin
                if (bus_ack) begin
                    state_d     = StIdle;
                    req_done_d  = grant_q;
                    last_d      = owner_q;
                    grant_d     = '0;
                    bus_valid_d = 1'b0;
                    bus_cs_d    = '0;
`ifdef ARB_TIMEOUT_EN
                end else if (cnt_q == CntW'(TIMEOUT_CYCLES)) begin
                    state_d     = StIdle;
                    req_done_d  = grant_q;
                    req_err_d   = 1'b1;
                    last_d      = owner_q;
                    grant_d     = '0;
                    bus_valid_d = 1'b0;
                    bus_cs_d    = '0;
                end else begin
                    cnt_d       = cnt_q + 1'b1;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            grant_q     <= '0;
            bus_valid_q <= 1'b0;
            bus_addr_q  <= '0;
            bus_cs_q    <= '0;
            req_done_q  <= '0;
            req_err_q   <= 1'b0;
            last_q      <= IdxW'(NUM_REQ - 1);
            owner_q     <= '0;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            bus_valid_q <= bus_valid_d;
            bus_addr_q  <= bus_addr_d;
            bus_cs_q    <= bus_cs_d;
            req_done_q  <= req_done_d;
            req_err_q   <= req_err_d;
            last_q      <= last_d;
            owner_q     <= owner_d;
`ifdef ARB_TIMEOUT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign grant     = grant_q;
    assign bus_valid = bus_valid_q;
    assign bus_addr  = bus_addr_q;
    assign bus_cs    = bus_cs_q;
    assign req_done  = req_done_q;
    assign req_err   = req_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expected grants/completions, monitor pops.
module tb_mem_port_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [79:0] req_addr;
    logic [3:0]  req_done;
    logic        req_err;
    logic [3:0]  grant;
    logic        bus_valid;
    logic [19:0] bus_addr;
    logic [15:0] bus_cs;
    logic        bus_ack;

    mem_port_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_done  (req_done),
        .req_err   (req_err),
        .grant     (grant),
        .bus_valid (bus_valid),
        .bus_addr  (bus_addr),
        .bus_cs    (bus_cs),
        .bus_ack   (bus_ack)
    );

    typedef struct {
        logic [3:0]  grant;
        logic [19:0] addr;
        logic [15:0] cs;
    } gnt_t;

    typedef struct {
        logic [3:0] done;
        logic       err;
    } done_t;

    gnt_t  exp_gnt[$];
    done_t exp_done[$];
    int    checks = 0;
    int    errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push_gnt(input logic [3:0] g, input logic [19:0] a, input logic [15:0] cs);
        gnt_t e;
        e.grant = g;
        e.addr  = a;
        e.cs    = cs;
        exp_gnt.push_back(e);
    endtask

    task automatic push_done(input logic [3:0] d, input logic err);
        done_t e;
        e.done = d;
        e.err  = err;
        exp_done.push_back(e);
    endtask

    task automatic wait_bus_valid(output int n);
        n = 0;
        while (!bus_valid && n < 30) begin
            cyc();
            n++;
        end
        chk("bus_valid_seen", 64'(bus_valid), 1);
    endtask

    task automatic set_addr(input int i, input logic [19:0] a);
        req_addr[i*20 +: 20] = a;
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    initial begin
        gnt_t  cur;
        done_t d;
        logic  bv_prev   = 1'b0;
        logic  done_prev = 1'b0;
        cur.grant = '0;
        cur.addr  = '0;
        cur.cs    = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_valid && !bv_prev) begin
                    if (exp_gnt.size() == 0) begin
                        chk("unexpected_grant", 64'(grant), 0);
                    end else begin
                        cur = exp_gnt.pop_front();
                        chk("grant", 64'(grant), 64'(cur.grant));
                        chk("bus_addr", 64'(bus_addr), 64'(cur.addr));
                        chk("bus_cs", 64'(bus_cs), 64'(cur.cs));
                    end
                end else if (bus_valid) begin
                    chk("frozen_addr", 64'(bus_addr), 64'(cur.addr));
                    chk("frozen_cs", 64'(bus_cs), 64'(cur.cs));
                end else begin
                    chk("idle_cs_grant", 64'({grant, bus_cs}), 0);
                end
                if (req_done != '0) begin
                    if (done_prev) chk("done_width", 64'(req_done), 0);
                    if (exp_done.size() == 0) begin
                        chk("unexpected_done", 64'(req_done), 0);
                    end else begin
                        d = exp_done.pop_front();
                        chk("req_done", 64'(req_done), 64'(d.done));
                        chk("req_err", 64'(req_err), 64'(d.err));
                    end
                end
                bv_prev   = bus_valid;
                done_prev = (req_done != '0);
            end else begin
                bv_prev   = 1'b0;
                done_prev = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        bus_ack   = 1'b0;
        #12;
        chk("rst_grant", 64'(grant), 0);
        chk("rst_bus_valid", 64'(bus_valid), 0);
        chk("rst_bus_addr", 64'(bus_addr), 0);
        chk("rst_bus_cs", 64'(bus_cs), 0);
        chk("rst_req_done", 64'(req_done), 0);
        chk("rst_req_err", 64'(req_err), 0);
        cyc();
        rst_n = 1'b1;
        cyc();

        // Single requester, ack two cycles after bus_valid.
        set_addr(0, 20'hA1234);
        req_valid = 4'b0001;
        push_gnt(4'b0001, 20'hA1234, 16'h0400);
        wait_bus_valid(n);
        chk("latency_t1", 64'(n), 1);
        repeat (2) cyc();
        bus_ack = 1'b1;
        push_done(4'b0001, 1'b0);
        cyc();
        bus_ack   = 1'b0;
        req_valid = '0;
        chk("t1_done_bubble", 64'(bus_valid), 0);
        repeat (2) cyc();

        // Owner changes address and drops request mid-transaction.
        set_addr(2, 20'h54321);
        req_valid = 4'b0100;
        push_gnt(4'b0100, 20'h54321, 16'h0020);
        wait_bus_valid(n);
        cyc();
        set_addr(2, 20'hC0000);
        req_valid = '0;
        cyc();
        chk("t3_addr_held", 64'(bus_addr), 64'(20'h54321));
        bus_ack = 1'b1;
        push_done(4'b0100, 1'b0);
        cyc();
        bus_ack = 1'b0;
        cyc();

        // Ack while idle is ignored.
        bus_ack = 1'b1;
        repeat (2) cyc();
        chk("idle_ack_valid", 64'(bus_valid), 0);
        chk("idle_ack_done", 64'(req_done), 0);
        bus_ack = 1'b0;
        cyc();

        // Reset during BUSY.
        set_addr(1, 20'h70000);
        req_valid = 4'b0010;
        push_gnt(4'b0010, 20'h70000, 16'h0080);
        wait_bus_valid(n);
        cyc();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outputs", 64'({grant, bus_valid, bus_cs, req_done, req_err}), 0);
        chk("mid_rst_addr", 64'(bus_addr), 0);
        set_addr(3, 20'h00010);
        req_valid = 4'b1111;
        repeat (2) cyc();
        rst_n = 1'b1;

        // All four requesting; requester 0 first after reset.
        push_gnt(4'b0001, 20'hA1234, 16'h0400);
        push_gnt(4'b0010, 20'h70000, 16'h0080);
        push_gnt(4'b0100, 20'hC0000, 16'h1000);
        push_gnt(4'b1000, 20'h00010, 16'h0001);
        push_gnt(4'b0001, 20'hA1234, 16'h0400);
        push_done(4'b0001, 1'b0);
        push_done(4'b0010, 1'b0);
        push_done(4'b0100, 1'b0);
        push_done(4'b1000, 1'b0);
        push_done(4'b0001, 1'b0);
        for (int k = 0; k < 5; k++) begin
            wait_bus_valid(n);
            chk("rr_gap", 64'(n), 1);
            cyc();
            bus_ack = 1'b1;
            cyc();
            bus_ack = 1'b0;
            if (k == 4) req_valid = '0;
            chk("rr_idle_bubble", 64'(bus_valid), 0);
        end
        repeat (2) cyc();

`ifdef ARB_TIMEOUT_EN
        // No ack: abort with error after the counter reaches its limit, then next owner.
        set_addr(0, 20'hA1234);
        set_addr(1, 20'h70000);
        req_valid = 4'b0011;
        push_gnt(4'b0010, 20'h70000, 16'h0080);
        push_done(4'b0010, 1'b1);
        push_gnt(4'b0001, 20'hA1234, 16'h0400);
        push_done(4'b0001, 1'b0);
        wait_bus_valid(n);
        n = 0;
        while (req_done == '0 && n < 40) begin
            cyc();
            n++;
        end
        chk("timeout_latency", 64'(n), 17);
        req_valid = 4'b0001;
        wait_bus_valid(n);
        repeat (16) cyc();
        bus_ack = 1'b1;
        cyc();
        bus_ack   = 1'b0;
        req_valid = '0;
        chk("ack_wins_done", 64'(req_done), 64'(4'b0001));
        chk("ack_wins_err", 64'(req_err), 0);
        repeat (2) cyc();
`endif

        repeat (3) cyc();
        chk("gnt_queue_drained", 64'(exp_gnt.size()), 0);
        chk("done_queue_drained", 64'(exp_done.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
